if_fetch_unit: RTL
==================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage: owns the PC, issues single-outstanding reads to instruction memory,
//  and buffers returned words for the IF/ID pipeline register.
//  Drives the pc/instruction inputs of IF/ID. Obeys the same freeze used by IF/ID.
//  Takes branch/jump redirects from EX, which also flush IF/ID.
// PARAMETERS
//  RESET_PC   32'h0000_0000  first fetch address after reset
//  NOP_INSTR  32'h0000_0013  word presented on instr_out when no valid instruction (addi x0,x0,0)
// PORTS
//  clk            in   1   clock
//  rstn           in   1   reset, synchronous, active-low
//  freeze         in   1   IF/ID hold; head entry is not consumed this cycle
//  redirect_valid in   1   taken branch/jump; discard everything in flight
//  redirect_pc    in   32  new fetch address; bits[1:0] ignored (forced 0)
//  imem_req       out  1   read request
//  imem_addr      out  32  read address, word aligned
//  imem_gnt       in   1   request accepted this cycle (req & gnt = handshake)
//  imem_rvalid    in   1   read data valid; earliest the cycle after gnt
//  imem_rdata     in   32  read data
//  pc_out         out  32  PC of head instruction (0 when empty)
//  instr_out      out  32  head instruction (NOP_INSTR when empty)
//  instr_valid    out  1   buffer non-empty
// BEHAVIOUR
//  Reset values (cycle after rstn low):
//  - imem_req=0, imem_addr=RESET_PC, pc_out=0, instr_out=NOP_INSTR, instr_valid=0
//  - fetch_pc=RESET_PC, buffer empty, state IDLE.
//  Buffer: 2-entry FIFO of {pc,instr}. Head is driven combinationally to pc_out/instr_out.
//  - pop = instr_valid & !freeze & !redirect_valid.
//  Memory access: at most 1 outstanding request.
//  - imem_req = (state==REQ) & (count<2), so a push can never overflow.
//  - imem_req/imem_addr hold stable until gnt, except on redirect.
//  FSM:
//  - IDLE: -> REQ next cycle; imem_rvalid ignored.
//  - REQ:  on req&gnt -> WAIT.
//          redirect: fetch_pc<=redirect_pc; if gnt same cycle -> DROP, else stay REQ.
//          Stray rvalid is ignored.
//  - WAIT: on rvalid: push {fetch_pc,rdata}, fetch_pc<=fetch_pc+4, -> REQ.
//          redirect: flush buffer, fetch_pc<=redirect_pc; rvalid same cycle -> REQ (data dropped), else -> DROP.
//  - DROP: on rvalid discard, -> REQ. Redirect in DROP: update fetch_pc, stay DROP.
//  Redirect (any state): buffer cleared same edge. Next cycle instr_valid=0, instr_out=NOP_INSTR.
//  Redirect has priority over freeze and over push.
//  Simultaneous push and pop: count unchanged.
//  PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 -> 32'h0000_0000.
//  Throughput with 1-cycle memory: 1 instruction per 2 cycles (gnt, rvalid, re-request). No prefetch beyond 1.
//  Reset mid-operation: in-flight request abandoned. A late rvalid lands in IDLE/REQ and is ignored.
// STRUCTURE
//  Package if_pkg:
//  - fetch_state_e {IDLE,REQ,WAIT,DROP}
//  - fetch_entry_t {logic[31:0] pc; logic[31:0] instr;}
//  - NOP_INSTR default constant
//  Sub-module fetch_buf: 2-entry FIFO with push, pop, flush, count[1:0], head.
//  - flush has priority over push.
//  Top: FSM, fetch_pc register, request gating.
// TESTING
//  1. Reset release, mem gnt immediate, rvalid +1 returning 0xA0/0xA1/0xA2:
//     - imem_addr 0x0,0x4,0x8
//     - instr_out sequence with pc_out 0x0,0x4,0x8
//  2. freeze=1 for 6 cycles with words streaming:
//     - req drops once count=2
//     - head stays pc 0x0
//     - on release pops 0x0 then 0x4 in order, no loss or duplicate
//  3. redirect_valid with redirect_pc=0x103 while in WAIT, rvalid 2 cycles later with 0xDEAD:
//     - 0xDEAD discarded
//     - next imem_addr=0x100
//     - instr_valid=0 the cycle after redirect
//  4. redirect and rvalid same cycle, and redirect and gnt same cycle:
//     - neither response is pushed
//     - first pushed pc equals redirect_pc
//  5. redirect_pc=0xFFFF_FFFC:
//     - fetch addresses 0xFFFF_FFFC then 0x0000_0000
//  6. rstn low in WAIT, stray rvalid after release:
//     - ignored
//     - first fetch at RESET_PC
//     - outputs at reset values

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of {pc, instr} sitting between instruction memory and IF/ID.
module fetch_buf
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_instr,
  output logic [1:0]  count,
  output logic [31:0] head_pc,
  output logic [31:0] head_instr
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  // Flush wins over both push and pop, so a redirect never leaves a stale word behind.
  assign do_push = push & ~flush & (count != 2'd2);
  assign do_pop  = pop & ~flush & (count != 2'd0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else if (flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr].pc    <= push_pc;
      mem[wr_ptr].instr <= push_instr;
    end
  end

  assign head_pc    = mem[rd_ptr].pc;
  assign head_instr = mem[rd_ptr].instr;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one memory read in flight and feeds IF/ID.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        freeze,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        instr_valid
);

  fetch_state_e state;
  logic [31:0]  fetch_pc;
  logic [31:0]  redirect_word;
  logic [1:0]   count;
  logic [31:0]  head_pc;
  logic [31:0]  head_instr;
  logic         handshake;
  logic         push;
  logic         pop;

  assign redirect_word = word_align(redirect_pc);

  // Requests are held back while the buffer is full so a returning word always has room.
  assign imem_req  = (state == REQ) && (count != 2'd2);
  assign imem_addr = fetch_pc;
  assign handshake = imem_req & imem_gnt;

  assign instr_valid = (count != 2'd0);
  assign pop         = instr_valid & ~freeze & ~redirect_valid;
  assign push        = (state == WAIT) & imem_rvalid & ~redirect_valid;

  assign pc_out    = instr_valid ? head_pc : 32'h0000_0000;
  assign instr_out = instr_valid ? head_instr : NOP_INSTR;

  fetch_buf u_fetch_buf (
    .clk        (clk),
    .rstn       (rstn),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .push_pc    (fetch_pc),
    .push_instr (imem_rdata),
    .count      (count),
    .head_pc    (head_pc),
    .head_instr (head_instr)
  );

  // DROP swallows the one response still owed by memory after a redirect.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          if (redirect_valid) fetch_pc <= redirect_word;
        end
        REQ: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_word;
            state    <= handshake ? DROP : REQ;
          end else if (handshake) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_word;
            state    <= imem_rvalid ? REQ : DROP;
          end else if (imem_rvalid) begin
            fetch_pc <= fetch_pc + 32'd4;
            state    <= REQ;
          end
        end
        DROP: begin
          if (redirect_valid) fetch_pc <= redirect_word;
          if (imem_rvalid) state <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
